if_id_hazard: RTL
=================

IF_ID_HAZARD -- requirements
Module: if_id_hazard

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 Instruction_if  in  32  fetched instruction from fetch stage.
REQ-004 NextPC_if  in  32  PC+4 of fetched instruction.
REQ-005 ex_memread, ex_rt  in  1, 5  EX-stage instruction is a load; its destination register.
REQ-006 mem_memread, mem_rt  in  1, 5  MEM-stage instruction is a load; its destination register.
REQ-007 BranchTaken  in  1  ID-stage branch comparator result for the instruction in ID (drives Z at fetch).
REQ-008 Instruction_id, NextPC_id  out  32, 32  IF/ID pipeline register contents.
REQ-009 valid_id  out  1  IF/ID holds a real (non-flushed) instruction.
REQ-010 PC_IFWrite  out  1  fetch-stage PC write enable; 0 = hold PC.
REQ-011 J, JR  out  1, 1  jump / jump-register select to fetch mux; never both 1.
REQ-012 JumpAddr  out  32  {NextPC_id[31:28], Instruction_id[25:0], 2'b00}.
REQ-013 bubble_id  out  1  ID/EX must load a NOP this cycle.

Function
REQ-014 Decode on Instruction_id: rs=[25:21], rt=[20:16], op=[31:26], funct=[5:0]; branch = op 000100 or 000101; jump = op 000010 or 000011; jr = op 000000 and funct 001000.
REQ-015 Load-use hazard: valid_id, ex_memread=1, ex_rt!=0, and ex_rt equals rs, or equals rt for op 000000/000100/000101.
REQ-016 Branch-load hazard: valid_id, (branch or jr), mem_memread=1, mem_rt!=0, mem_rt equals rs (or rt for branch).
REQ-017 stall = load-use hazard OR branch-load hazard (combinational); PC_IFWrite = ~stall; bubble_id = stall.
REQ-018 lw followed immediately by dependent beq stalls exactly 2 cycles (EX match, then MEM match); dependent ALU op stalls exactly 1.
REQ-019 J = valid_id & jump & ~stall; JR = valid_id & jr & ~stall; both 0 while stall.
REQ-020 flush = ~stall & (J | JR | (valid_id & branch & BranchTaken)).
REQ-021 IF/ID update per edge, priority: stall -> hold all; flush -> Instruction_id=0, NextPC_id=NextPC_if, valid_id=0; else load Instruction_if, NextPC_if, valid_id=1.
REQ-022 BranchTaken is ignored while stall=1 or valid_id=0; simultaneous stall and BranchTaken -> stall wins, no flush.
REQ-023 Register $0 never causes a hazard; Instruction_id=0 (NOP) never stalls.
REQ-024 Flush penalty exactly 1 cycle; stall and flush never extend beyond the conditions above.

Reset
REQ-025 On reset: Instruction_id=0, NextPC_id=0, valid_id=0; hence PC_IFWrite=1, J=JR=0, bubble_id=0, JumpAddr=0.
REQ-026 Reset asserted mid-stall or mid-flush discards the pending instruction; first edge after release loads Instruction_if.

Configuration
REQ-027 Macro HAZARD_STATS_EN defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0], each increments by 1 on every edge with stall / flush respectively, saturates at 16'hFFFF, clears on reset.
REQ-028 Macro undefined: those ports and counters do not exist; all other behaviour identical.

Verification
REQ-029 lw $2,0($1) in EX (ex_memread=1, ex_rt=2), add $3,$2,$4 in ID -> PC_IFWrite=0, bubble_id=1 for 1 cycle, Instruction_id held, then advances.
REQ-030 lw $5 then beq $5,$0 back-to-back -> PC_IFWrite=0 for exactly 2 consecutive cycles; with BranchTaken=1 afterwards, 1 flush cycle, valid_id=0.
REQ-031 Instruction_id=0x0800_0010, NextPC_id=0x0040_0008 -> J=1, JumpAddr=0x0000_0040, next Instruction_id=0, valid_id=0.
REQ-032 jr $31 (0x03E0_0008) with mem_memread=1, mem_rt=31 -> JR=0, stall 1 cycle, then JR=1 and flush.
REQ-033 Stall condition with BranchTaken=1 in same cycle -> no flush; reset asserted during stall -> all outputs to REQ-025 values immediately.
REQ-034 With HAZARD_STATS_EN: 3 stalls + 2 flushes -> stall_cnt=3, flush_cnt=2; forced 70000 stalls -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/if_id_hazard_if.sv
// -----------------------------------------------------------------------------
// if_id_hazard_if
//   Bundles the fetch-side inputs and IF/ID-side outputs of the IF/ID hazard
//   unit.
//
//   master : pipeline side; drives fetch/EX/MEM/branch info, observes
//            the IF/ID register and the hazard controls.
//   slave  : the hazard unit itself (if_id_hazard).
//
//   Signals
//     Instruction_if, NextPC_if     fetched instruction and its PC+4
//     ex_memread, ex_rt             EX-stage load and its destination reg
//     mem_memread, mem_rt           MEM-stage load and its destination reg
//     BranchTaken                   ID-stage branch comparator result
//     Instruction_id, NextPC_id     IF/ID register contents
//     valid_id                      IF/ID holds a real instruction
//     PC_IFWrite                    PC write enable (0 = hold PC)
//     J, JR, JumpAddr               jump selects and jump target
//     bubble_id                     ID/EX must load a NOP
//     stall_cnt, flush_cnt          only when HAZARD_STATS_EN is defined
// -----------------------------------------------------------------------------
interface if_id_hazard_if;
    logic [31:0] Instruction_if;
    logic [31:0] NextPC_if;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        mem_memread;
    logic [4:0]  mem_rt;
    logic        BranchTaken;

    logic [31:0] Instruction_id;
    logic [31:0] NextPC_id;
    logic        valid_id;
    logic        PC_IFWrite;
    logic        J;
    logic        JR;
    logic [31:0] JumpAddr;
    logic        bubble_id;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    modport master (
        output Instruction_if, NextPC_if,
        output ex_memread, ex_rt, mem_memread, mem_rt, BranchTaken,
        input  Instruction_id, NextPC_id, valid_id,
        input  PC_IFWrite, J, JR, JumpAddr, bubble_id
`ifdef HAZARD_STATS_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  Instruction_if, NextPC_if,
        input  ex_memread, ex_rt, mem_memread, mem_rt, BranchTaken,
        output Instruction_id, NextPC_id, valid_id,
        output PC_IFWrite, J, JR, JumpAddr, bubble_id
`ifdef HAZARD_STATS_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/if_id_hazard.sv
// -----------------------------------------------------------------------------
// if_id_hazard
//   IF/ID pipeline register with load-use / branch-load stall detection and
//   jump / taken-branch flush control for a classic 5-stage MIPS pipeline.
//
//   Ports
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high; clears the IF/ID register
//     bus    : if_id_hazard_if.slave (fetch inputs, EX/MEM load info,
//              BranchTaken; IF/ID contents, PC_IFWrite, J, JR, JumpAddr,
//              bubble_id)
//
//   Optional build macro
//     HAZARD_STATS_EN : adds saturating 16-bit stall_cnt / flush_cnt on the
//                       interface, counting edges with stall / flush.
// -----------------------------------------------------------------------------
module if_id_hazard (
    input  logic           clk,
    input  logic           reset,
    if_id_hazard_if.slave  bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // IF/ID register
    logic [31:0] r_instr_id;
    logic [31:0] r_npc_id;
    logic        r_valid_id;

    // decode of the instruction in ID
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_is_branch;
    logic        w_is_jump;
    logic        w_is_jr;
    logic        w_uses_rt;

    // hazard / control
    logic        w_load_use;
    logic        w_branch_load;
    logic        w_stall;
    logic        w_j;
    logic        w_jr;
    logic        w_flush;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        w_op        = r_instr_id[31:26];
        w_rs        = r_instr_id[25:21];
        w_rt        = r_instr_id[20:16];
        w_funct     = r_instr_id[5:0];
        w_is_branch = (w_op == OP_BEQ) || (w_op == OP_BNE);
        w_is_jump   = (w_op == OP_J)   || (w_op == OP_JAL);
        w_is_jr     = (w_op == OP_RTYPE) && (w_funct == FN_JR);
        // rt is a source only for R-type and branches; for I-type it is the
        // destination and must not trigger a load-use stall.
        w_uses_rt   = (w_op == OP_RTYPE) || w_is_branch;
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        w_load_use    = 1'b0;
        w_branch_load = 1'b0;

        // Load in EX feeding any consumer in ID.  ex_rt != 0 keeps $0 and
        // the all-zero NOP from ever stalling.
        if (r_valid_id && bus.ex_memread && (bus.ex_rt != 5'd0)) begin
            if ((bus.ex_rt == w_rs) || (w_uses_rt && (bus.ex_rt == w_rt)))
                w_load_use = 1'b1;
        end

        // Branch / jr resolve in ID, so a load still in MEM is too late to
        // forward; stall one more cycle.
        if (r_valid_id && (w_is_branch || w_is_jr) &&
            bus.mem_memread && (bus.mem_rt != 5'd0)) begin
            if ((bus.mem_rt == w_rs) || (w_is_branch && (bus.mem_rt == w_rt)))
                w_branch_load = 1'b1;
        end

        w_stall = w_load_use || w_branch_load;
    end

    // ------------------------------------------------------------------
    // Jump selects and flush; stall suppresses every redirect.
    // ------------------------------------------------------------------
    always_comb begin
        w_j     = r_valid_id && w_is_jump && !w_stall;
        w_jr    = r_valid_id && w_is_jr   && !w_stall;
        w_flush = !w_stall &&
                  (w_j || w_jr || (r_valid_id && w_is_branch && bus.BranchTaken));
    end

    // ------------------------------------------------------------------
    // IF/ID register: stall holds, flush inserts an invalid NOP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_id <= '0;
            r_npc_id   <= '0;
            r_valid_id <= 1'b0;
        end else if (w_stall) begin
            r_instr_id <= r_instr_id;
            r_npc_id   <= r_npc_id;
            r_valid_id <= r_valid_id;
        end else if (w_flush) begin
            r_instr_id <= '0;
            r_npc_id   <= bus.NextPC_if;
            r_valid_id <= 1'b0;
        end else begin
            r_instr_id <= bus.Instruction_if;
            r_npc_id   <= bus.NextPC_if;
            r_valid_id <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.Instruction_id = r_instr_id;
    assign bus.NextPC_id      = r_npc_id;
    assign bus.valid_id       = r_valid_id;
    assign bus.PC_IFWrite     = ~w_stall;
    assign bus.bubble_id      = w_stall;
    assign bus.J              = w_j;
    assign bus.JR             = w_jr;
    assign bus.JumpAddr       = {r_npc_id[31:28], r_instr_id[25:0], 2'b00};

`ifdef HAZARD_STATS_EN
    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule
